// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forward-select encoding and scoreboard entry.
// Decode_stage also imports fwd_sel_t.
package hazard_pkg;

    localparam int SB_DEST_W = 5;
    localparam logic [SB_DEST_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_GPR = 2'b00,
        FWD_MEM = 2'b01,
        FWD_EXE = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                 valid;
        logic [SB_DEST_W-1:0] dest;
        logic                 reg_write;
        logic                 mem_read;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/hazard_match.sv
// Compares one scoreboard slot against one decode operand.
// Register 0 is hard-wired, so it never produces a match.
module hazard_match
    import hazard_pkg::*;
(
    input  sb_entry_t             entry,
    input  logic [SB_DEST_W-1:0]  idx,
    input  logic                  use_idx,
    output logic                  match,
    output logic                  is_load
);

    assign match   = use_idx && (idx != REG_ZERO) && entry.valid &&
                     entry.reg_write && (entry.dest == idx);
    assign is_load = match && entry.mem_read;

endmodule

// File: rtl/hazard_unit.sv
// Forwarding selects and load-use stall/bubble generation from a private
// EXE/MEM/WB scoreboard fed by the instruction in decode.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = SB_DEST_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  uses_rs,
    input  logic                  uses_rt,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_dest,
    input  logic                  dec_reg_write,
    input  logic                  dec_mem_read,
    input  logic                  ext_stall,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall,
    output logic                  bubble,
    output logic [CNT_W-1:0]      stall_count
);

    // Scoreboard tags are stored at the package width; REG_ADDR_W must match it.
    sb_entry_t exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sb_entry_t                 slot [2];
    logic [1:0][SB_DEST_W-1:0] op_idx;
    logic [1:0]                op_use;
    logic [1:0][1:0]           hit;
    logic [1:0][1:0]           ld;
    logic                      hazard;
    fwd_sel_t                  fwd [2];

    assign slot[0] = exe_q;
    assign slot[1] = mem_q;
    assign op_idx  = {SB_DEST_W'(rt), SB_DEST_W'(rs)};
    assign op_use  = {uses_rt, uses_rs};

    for (genvar s = 0; s < 2; s++) begin : g_slot
        for (genvar o = 0; o < 2; o++) begin : g_op
            hazard_match u_match (
                .entry   (slot[s]),
                .idx     (op_idx[o]),
                .use_idx (op_use[o]),
                .match   (hit[s][o]),
                .is_load (ld[s][o])
            );
        end
    end

    // Load data is on neither forwarding bus, so any load match must wait.
    assign hazard = dec_valid && (|ld);

    always_comb begin
        for (int o = 0; o < 2; o++) begin
            fwd[o] = FWD_GPR;
            if (!hazard) begin
                if (hit[0][o] && !ld[0][o])
                    fwd[o] = FWD_EXE;
                else if (hit[1][o] && !ld[1][o])
                    fwd[o] = FWD_MEM;
            end
        end
    end

    assign forward_a   = fwd[0];
    assign forward_b   = fwd[1];
    assign stall       = hazard || ext_stall;
    assign bubble      = hazard && !ext_stall;
    assign stall_count = cnt_q;

    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        cnt_d = cnt_q;
        if (!ext_stall) begin
            wb_d  = mem_q;
            mem_d = exe_q;
            if (hazard) begin
                exe_d = SB_EMPTY;
                if (cnt_q != '1)
                    cnt_d = cnt_q + CNT_W'(1);
            end else begin
                exe_d.valid     = dec_valid;
                exe_d.dest      = SB_DEST_W'(dec_dest);
                exe_d.reg_write = dec_reg_write;
                exe_d.mem_read  = dec_mem_read;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exe_q <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            wb_q  <= SB_EMPTY;
            cnt_q <= '0;
        end else begin
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: one table row per decode cycle,
// plus a hand-written reset-during-stall sequence.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs, rt, dec_dest;
    logic        uses_rs, uses_rt, dec_valid, dec_reg_write, dec_mem_read, ext_stall;
    logic [1:0]  forward_a, forward_b, s_fa, s_fb;
    logic        stall, bubble, s_stall, s_bubble;
    logic [31:0] stall_count;
    logic [1:0]  s_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .uses_rs(uses_rs), .uses_rt(uses_rt),
        .dec_valid(dec_valid), .dec_dest(dec_dest), .dec_reg_write(dec_reg_write),
        .dec_mem_read(dec_mem_read), .ext_stall(ext_stall), .forward_a(forward_a),
        .forward_b(forward_b), .stall(stall), .bubble(bubble), .stall_count(stall_count)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    hazard_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .uses_rs(uses_rs), .uses_rt(uses_rt),
        .dec_valid(dec_valid), .dec_dest(dec_dest), .dec_reg_write(dec_reg_write),
        .dec_mem_read(dec_mem_read), .ext_stall(ext_stall), .forward_a(s_fa),
        .forward_b(s_fb), .stall(s_stall), .bubble(s_bubble), .stall_count(s_count)
    );

    typedef struct {
        logic       dv;
        logic [4:0] dest;
        logic       rw, mr;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic       ext;
        logic [1:0] fa, fb;
        logic       st, bu;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic dv, int dest, logic rw, logic mr, int rsi, logic urs,
                                int rti, logic urt, logic ext, logic [1:0] fa, logic [1:0] fb,
                                logic st, logic bu, int cnt);
        vec_t v;
        v.dv = dv; v.dest = 5'(dest); v.rw = rw; v.mr = mr;
        v.rs = 5'(rsi); v.urs = urs; v.rt = 5'(rti); v.urt = urt; v.ext = ext;
        v.fa = fa; v.fb = fb; v.st = st; v.bu = bu; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        dec_valid = v.dv; dec_dest = v.dest; dec_reg_write = v.rw; dec_mem_read = v.mr;
        rs = v.rs; uses_rs = v.urs; rt = v.rt; uses_rt = v.urt; ext_stall = v.ext;
    endtask

    task automatic check_row(input string tag, input vec_t v);
        chk({tag, " forward_a"},   32'(forward_a), 32'(v.fa));
        chk({tag, " forward_b"},   32'(forward_b), 32'(v.fb));
        chk({tag, " stall"},       32'(stall),     32'(v.st));
        chk({tag, " bubble"},      32'(bubble),    32'(v.bu));
        chk({tag, " stall_count"}, stall_count,    32'(v.cnt));
    endtask

    initial begin
        vec_t idle, lw7, use7;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        apply(idle);
        reset = 1'b1;
        #12;
        check_row("reset", idle);
        chk("reset sat_count", 32'(s_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        //             dv dst rw mr rs urs rt urt ext  fa     fb    st bu cnt
        tbl.push_back(mk(1, 3, 1, 0, 1, 1, 2, 1, 0, 2'b00, 2'b00, 0, 0, 0)); // add r3
        tbl.push_back(mk(1, 5, 1, 0, 3, 1, 4, 1, 0, 2'b10, 2'b00, 0, 0, 0)); // sub r5,r3,r4
        tbl.push_back(mk(1, 3, 1, 0, 1, 1, 2, 1, 0, 2'b00, 2'b00, 0, 0, 0)); // add r3
        tbl.push_back(mk(1, 3, 1, 0, 3, 1, 2, 1, 0, 2'b10, 2'b00, 0, 0, 0)); // add r3,r3
        tbl.push_back(mk(1, 0, 0, 0, 3, 1, 2, 1, 0, 2'b10, 2'b00, 0, 0, 0)); // r3 in EXE+MEM
        tbl.push_back(mk(1, 9, 0, 0, 3, 1, 3, 1, 0, 2'b01, 2'b01, 0, 0, 0)); // non-writer in EXE
        tbl.push_back(mk(1,10, 0, 0, 3, 1, 3, 1, 0, 2'b00, 2'b00, 0, 0, 0)); // r3 only in WB
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0)); // addi r0
        tbl.push_back(mk(1,11, 1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0)); // read r0
        tbl.push_back(mk(1, 0, 1, 1, 2, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0)); // lw r0
        tbl.push_back(mk(1,12, 1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0)); // read r0 after lw
        tbl.push_back(idle);
        tbl.push_back(mk(1, 7, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0)); // lw r7
        tbl.push_back(mk(1, 8, 1, 0, 7, 1, 7, 1, 0, 2'b00, 2'b00, 1, 1, 0)); // add r8,r7,r7
        tbl.push_back(mk(1, 8, 1, 0, 7, 1, 7, 1, 0, 2'b00, 2'b00, 1, 1, 1));
        tbl.push_back(mk(1, 8, 1, 0, 7, 1, 7, 1, 0, 2'b00, 2'b00, 0, 0, 2));
        tbl.push_back(mk(1, 9, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2)); // lw r9
        tbl.push_back(mk(1,13, 1, 0, 9, 1, 8, 1, 0, 2'b00, 2'b00, 1, 1, 2)); // use r9, r8 in MEM
        tbl.push_back(mk(1,13, 1, 0, 9, 1, 8, 1, 1, 2'b00, 2'b00, 1, 0, 3)); // freeze x3
        tbl.push_back(mk(1,13, 1, 0, 9, 1, 8, 1, 1, 2'b00, 2'b00, 1, 0, 3));
        tbl.push_back(mk(1,13, 1, 0, 9, 1, 8, 1, 1, 2'b00, 2'b00, 1, 0, 3));
        tbl.push_back(mk(1,13, 1, 0, 9, 1, 8, 1, 0, 2'b00, 2'b00, 1, 1, 3));
        tbl.push_back(mk(1,13, 1, 0, 9, 1, 8, 1, 0, 2'b00, 2'b00, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0, 4)); // freeze, no hazard
        tbl.push_back(mk(1,14, 1, 1,13, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 4)); // lw r14 uses r13
        tbl.push_back(mk(0, 0, 0, 0,14, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 4)); // invalid decode

        foreach (tbl[i]) begin
            apply(tbl[i]);
            #3;
            check_row($sformatf("row%0d", i), tbl[i]);
            @(posedge clk); #1;
        end
        chk("saturated count", 32'(s_count), 32'd3);

        // Reset during the first load-use stall cycle.
        lw7  = mk(1, 7, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        use7 = mk(1, 8, 1, 0, 7, 1, 7, 1, 0, 2'b00, 2'b00, 0, 0, 0);
        apply(lw7);
        @(posedge clk); #1;
        apply(use7);
        #2;
        chk("pre-reset stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid-reset stall",     32'(stall),     32'd0);
        chk("mid-reset bubble",    32'(bubble),    32'd0);
        chk("mid-reset forward_a", 32'(forward_a), 32'd0);
        chk("mid-reset forward_b", 32'(forward_b), 32'd0);
        chk("mid-reset count",     stall_count,    32'd0);
        chk("mid-reset sat_count", 32'(s_count),   32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #3;
        check_row("post-reset", use7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
